// File: rtl/act_sweep_checker_if.sv
// Mismatch-record readout port for act_sweep_checker.
// The master side presents the head record of the mismatch FIFO with a valid flag.
// The slave side accepts that record with err_ready.
interface act_sweep_checker_if #(
    parameter int DATA_W = 8
);
    logic              err_valid;
    logic              err_ready;
    logic [DATA_W-1:0] err_x;
    logic [DATA_W-1:0] err_a;
    logic [DATA_W-1:0] err_b;

    modport master (
        output err_valid,
        output err_x,
        output err_a,
        output err_b,
        input  err_ready
    );

    modport slave (
        input  err_valid,
        input  err_x,
        input  err_a,
        input  err_b,
        output err_ready
    );
endinterface

// File: rtl/act_sweep_checker.sv
// act_sweep_checker: drives an exhaustive signed sweep into two activation units,
// compares their responses LATENCY cycles later against a tolerance, and queues
// mismatch records {x, y_a, y_b} in a small FIFO that is read out over err.
// Optional feature macro: ERR_HIST_EN adds the error histogram outputs hist0..hist3.
module act_sweep_checker #(
    parameter int DATA_W     = 8,
    parameter int LATENCY    = 1,   // 1..4
    parameter int TOL        = 1,
    parameter int FIFO_DEPTH = 16   // power of 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   x_out,
    input  logic [DATA_W-1:0]   y_a_in,
    input  logic [DATA_W-1:0]   y_b_in,
    act_sweep_checker_if.master err,
    output logic [DATA_W:0]     mismatch_cnt,
    output logic [DATA_W:0]     max_err,
    output logic                overflow
`ifdef ERR_HIST_EN
    ,
    output logic [DATA_W:0]     hist0,
    output logic [DATA_W:0]     hist1,
    output logic [DATA_W:0]     hist2,
    output logic [DATA_W:0]     hist3
`endif
);
    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              RW         = 3 * DATA_W;
    localparam logic [DATA_W-1:0] X_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] X_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] X_ONE    = DATA_W'(1);
    localparam logic [DATA_W:0]   ONE_W    = (DATA_W+1)'(1);
    localparam logic [DATA_W:0]   TOL_W    = (DATA_W+1)'(TOL);
    localparam logic [2:0]        DRAIN_LAST = 3'(LATENCY - 1);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] x_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [2:0]        drain_cnt_reg;

    // start is only honoured when no sweep is in progress; it also wipes the results
    logic sweep_clear;
    assign sweep_clear = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // Sweep sequencer: IDLE/DONE -> DRIVE (one x per cycle) -> DRAIN (LATENCY cycles) -> DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            x_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            drain_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg <= S_DRIVE;
                        x_reg     <= X_MIN;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (x_reg == X_MAX) begin
                        state_reg     <= S_DRAIN;
                        drain_cnt_reg <= '0;
                    end else begin
                        x_reg <= x_reg + X_ONE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 3'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign x_out = x_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

    // Tag pipeline: stage LATENCY-1 names the stimulus whose response is on y_*_in now
    logic              tag_v_reg [LATENCY];
    logic [DATA_W-1:0] tag_x_reg [LATENCY];

    // Shift stimulus and its valid bit alongside the external DUT pipelines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_v_reg[i] <= 1'b0;
                tag_x_reg[i] <= '0;
            end
        end else begin
            tag_v_reg[0] <= (state_reg == S_DRIVE);
            tag_x_reg[0] <= x_reg;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v_reg[i] <= tag_v_reg[i-1];
                tag_x_reg[i] <= tag_x_reg[i-1];
            end
        end
    end

    // Response comparison: widen by one bit so the difference never overflows
    logic              cap_v;
    logic [DATA_W-1:0] cap_x;
    logic [DATA_W:0]   a_ext;
    logic [DATA_W:0]   b_ext;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   abs_diff;
    logic              is_mis;

    assign cap_v    = tag_v_reg[LATENCY-1];
    assign cap_x    = tag_x_reg[LATENCY-1];
    assign a_ext    = {y_a_in[DATA_W-1], y_a_in};
    assign b_ext    = {y_b_in[DATA_W-1], y_b_in};
    assign diff     = a_ext - b_ext;
    assign abs_diff = diff[DATA_W] ? (~diff + ONE_W) : diff;
    assign is_mis   = cap_v && (abs_diff > TOL_W);

    // Mismatch FIFO: a pop in the same cycle frees a slot for a push into a full FIFO
    logic [RW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_full;
    logic          pop;
    logic          push;

    assign fifo_full = (count_reg == CNT_FULL);
    assign pop       = (count_reg != '0) && err.err_ready;
    assign push      = is_mis && (!fifo_full || pop);

    // Record storage: plain array write so it maps onto distributed/block RAM
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cap_x, y_a_in, y_b_in};
        end
    end

    // FIFO bookkeeping; a new sweep flushes any records left from the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (sweep_clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign err.err_valid = (count_reg != '0);
    assign {err.err_x, err.err_a, err.err_b} = fifo_mem[rd_ptr_reg];

    logic [DATA_W:0] mismatch_cnt_reg;
    logic [DATA_W:0] max_err_reg;
    logic            overflow_reg;

    // Per-sweep statistics; overflow is sticky until the next start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_cnt_reg <= '0;
            max_err_reg      <= '0;
            overflow_reg     <= 1'b0;
        end else if (sweep_clear) begin
            mismatch_cnt_reg <= '0;
            max_err_reg      <= '0;
            overflow_reg     <= 1'b0;
        end else if (cap_v) begin
            if (abs_diff > max_err_reg) max_err_reg <= abs_diff;
            if (is_mis) mismatch_cnt_reg <= mismatch_cnt_reg + ONE_W;
            if (is_mis && fifo_full && !pop) overflow_reg <= 1'b1;
        end
    end

    assign mismatch_cnt = mismatch_cnt_reg;
    assign max_err      = max_err_reg;
    assign overflow     = overflow_reg;

`ifdef ERR_HIST_EN
    logic [DATA_W:0] hist0_reg, hist1_reg, hist2_reg, hist3_reg;

    // Error histogram: bins diff==0, ==1, 2..3, >=4
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist0_reg <= '0;
            hist1_reg <= '0;
            hist2_reg <= '0;
            hist3_reg <= '0;
        end else if (sweep_clear) begin
            hist0_reg <= '0;
            hist1_reg <= '0;
            hist2_reg <= '0;
            hist3_reg <= '0;
        end else if (cap_v) begin
            if (abs_diff == '0)                        hist0_reg <= hist0_reg + ONE_W;
            else if (abs_diff == ONE_W)                hist1_reg <= hist1_reg + ONE_W;
            else if (abs_diff <= (DATA_W+1)'(3))       hist2_reg <= hist2_reg + ONE_W;
            else                                       hist3_reg <= hist3_reg + ONE_W;
        end
    end

    assign hist0 = hist0_reg;
    assign hist1 = hist1_reg;
    assign hist2 = hist2_reg;
    assign hist3 = hist3_reg;
`endif
endmodule

// File: tb/tb_act_sweep_checker.sv
// Testbench for act_sweep_checker: the bench plays both activation units as lookup
// tables behind a LAT-cycle delay line, and a queue-based model predicts every output.
module tb_act_sweep_checker;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int TOL   = 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] x_out;
    logic [DW-1:0] y_a_in;
    logic [DW-1:0] y_b_in;
    logic [DW:0]   mismatch_cnt;
    logic [DW:0]   max_err;
    logic          overflow;
`ifdef ERR_HIST_EN
    logic [DW:0]   hist0, hist1, hist2, hist3;
`endif

    act_sweep_checker_if #(.DATA_W(DW)) eif ();

    always #5 clk = ~clk;

    act_sweep_checker #(
        .DATA_W(DW), .LATENCY(LAT), .TOL(TOL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .x_out(x_out), .y_a_in(y_a_in), .y_b_in(y_b_in), .err(eif),
        .mismatch_cnt(mismatch_cnt), .max_err(max_err), .overflow(overflow)
`ifdef ERR_HIST_EN
        , .hist0(hist0), .hist1(hist1), .hist2(hist2), .hist3(hist3)
`endif
    );

    // Two activation "units": lookup tables indexed by the raw x bits, LAT cycles deep
    logic [7:0] lut_a [256];
    logic [7:0] lut_b [256];
    logic [7:0] xd    [LAT];

    always @(posedge clk) begin
        xd[0] <= x_out;
        for (int i = 1; i < LAT; i++) xd[i] <= xd[i-1];
    end

    assign y_a_in = lut_a[xd[LAT-1]];
    assign y_b_in = lut_b[xd[LAT-1]];

    // Model state: n = clock edges since the edge that accepted start
    int          n;
    bit          started;
    int          exp_cnt, exp_max;
    bit          exp_ovf;
    int          exp_hist [4];
    logic [23:0] q      [$];
    logic [23:0] popped [$];
    bit          saw_valid;
    int          checks = 0;
    int          passes = 0;

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic void chk(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endfunction

    function automatic void model_clear();
        exp_cnt = 0;
        exp_max = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 4; i++) exp_hist[i] = 0;
        q.delete();
    endfunction

    // Advance the model by one clock edge given the inputs the DUT sampled there
    function automatic void model_edge(input bit st, input bit rdy, input bit rst);
        bit          do_pop, do_push;
        int          k, a, b, d;
        logic [7:0]  xb;
        logic [23:0] rec;
        if (rst) begin
            started = 1'b0;
            n = 0;
            model_clear();
            return;
        end
        if (st && !(started && n < 256 + LAT)) begin
            started = 1'b1;
            n = 0;
            model_clear();
            return;
        end
        do_pop  = (q.size() > 0) && rdy;
        do_push = 1'b0;
        xb      = 8'h00;
        if (started) begin
            n++;
            k = n - LAT - 1;
            if (k >= 0 && k <= 255) begin
                xb = 8'(k - 128);
                a  = sx(lut_a[xb]);
                b  = sx(lut_b[xb]);
                d  = (a > b) ? a - b : b - a;
                if (d > exp_max) exp_max = d;
                if (d == 0)      exp_hist[0]++;
                else if (d == 1) exp_hist[1]++;
                else if (d <= 3) exp_hist[2]++;
                else             exp_hist[3]++;
                if (d > TOL) begin
                    exp_cnt++;
                    if (q.size() < DEPTH || do_pop) do_push = 1'b1;
                    else exp_ovf = 1'b1;
                end
            end
        end
        if (do_pop) begin
            rec = q.pop_front();
            popped.push_back(rec);
            $display("pop  x=%0d a=%0d b=%0d", sx(rec[23:16]), sx(rec[15:8]), sx(rec[7:0]));
        end
        if (do_push) q.push_back({xb, lut_a[xb], lut_b[xb]});
    endfunction

    // Per-cycle comparison of every meaningful output against the model
    task automatic compare();
        int exp_x;
        exp_x = !started ? 0 : (n < 256 ? n - 128 : 127);
        chk("x_out", sx(x_out), exp_x);
        chk("busy", int'(busy), int'(started && n < 256 + LAT));
        chk("done", int'(done), int'(started && n >= 256 + LAT));
        chk("mismatch_cnt", int'(mismatch_cnt), exp_cnt);
        chk("max_err", int'(max_err), exp_max);
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("err_valid", int'(eif.err_valid), int'(q.size() > 0));
        if (q.size() > 0) begin
            chk("err_x", int'(eif.err_x), int'(q[0][23:16]));
            chk("err_a", int'(eif.err_a), int'(q[0][15:8]));
            chk("err_b", int'(eif.err_b), int'(q[0][7:0]));
        end
`ifdef ERR_HIST_EN
        chk("hist0", int'(hist0), exp_hist[0]);
        chk("hist1", int'(hist1), exp_hist[1]);
        chk("hist2", int'(hist2), exp_hist[2]);
        chk("hist3", int'(hist3), exp_hist[3]);
`endif
        if (eif.err_valid) saw_valid = 1'b1;
    endtask

    // One clock: choose err_ready (0 never, 1 always, 2 half, 3 quarter), clock, model, compare
    task automatic step(input int mode);
        case (mode)
            0:       eif.err_ready = 1'b0;
            1:       eif.err_ready = 1'b1;
            2:       eif.err_ready = 1'($urandom_range(0, 1));
            default: eif.err_ready = ($urandom_range(0, 3) == 0);
        endcase
        @(posedge clk);
        model_edge(start, eif.err_ready, reset);
        #1;
        compare();
    endtask

    // Full sweep from IDLE/DONE; optionally pulse start again mid-sweep at edge mid_at
    task automatic run_sweep(input int mode, input int mid_at);
        int steps;
        popped.delete();
        saw_valid = 1'b0;
        start = 1'b1;
        step(mode);
        start = 1'b0;
        steps = 1;
        chk("start_clr_cnt", int'(mismatch_cnt), 0);
        chk("start_clr_max", int'(max_err), 0);
        chk("start_clr_ovf", int'(overflow), 0);
        chk("start_flush", int'(eif.err_valid), 0);
        chk("start_busy", int'(busy), 1);
        chk("start_x", sx(x_out), -128);
        while (!done && steps < 700) begin
            if (steps == mid_at) start = 1'b1;
            step(mode);
            start = 1'b0;
            steps++;
        end
        if (!done) chk("done_timeout", 0, 1);
        else       chk("done_latency", steps, 257 + LAT);
        $display("sweep done cnt=%0d max=%0d ovf=%0d", mismatch_cnt, max_err, overflow);
    endtask

    task automatic small_diff_luts();
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'($urandom_range(0, 200) - 100);
            lut_b[i] = 8'(sx(lut_a[i]) + $urandom_range(0, 6) - 3);
        end
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        start = 1'b0;
        eif.err_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'h00;
            lut_b[i] = 8'h00;
        end
        model_edge(1'b0, 1'b0, 1'b1);
        step(0);
        step(0);
        #2 reset = 1'b0;
        #1;
        chk("rst_x", sx(x_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(mismatch_cnt), 0);
        chk("rst_max", int'(max_err), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_valid", int'(eif.err_valid), 0);

        // Identical units: no mismatches at all
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'($urandom);
            lut_b[i] = lut_a[i];
        end
        run_sweep(2, -1);
        chk("s1_cnt", int'(mismatch_cnt), 0);
        chk("s1_max", int'(max_err), 0);
        chk("s1_never_valid", int'(saw_valid), 0);

        // Single mismatch of 2 at x=5
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'($urandom);
            lut_b[i] = lut_a[i];
        end
        lut_a[5] = 8'd40;
        lut_b[5] = 8'd42;
        run_sweep(1, -1);
        chk("s2_cnt", int'(mismatch_cnt), 1);
        chk("s2_max", int'(max_err), 2);
        chk("s2_nrec", popped.size(), 1);
        if (popped.size() > 0) chk("s2_rec", int'(popped[0]), 24'h05282A);

        // Every sample mismatches by 255 with a stalled consumer
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'h7F;
            lut_b[i] = 8'h80;
        end
        run_sweep(0, -1);
        chk("s3_cnt", int'(mismatch_cnt), 256);
        chk("s3_max", int'(max_err), 255);
        chk("s3_ovf", int'(overflow), 1);
        chk("s3_valid", int'(eif.err_valid), 1);
        repeat (20) step(1);
        chk("s3_nrec", popped.size(), 16);
        if (popped.size() == 16) begin
            chk("s3_first_x", int'(popped[0][23:16]), 8'h80);
            chk("s3_last_x", int'(popped[15][23:16]), 8'h8F);
            chk("s3_first_ab", int'(popped[0][15:0]), 16'h7F80);
        end
        chk("s3_drained", int'(eif.err_valid), 0);

        // Refill the FIFO, then restart from DONE with a stray start mid-sweep
        run_sweep(0, -1);
        small_diff_luts();
        run_sweep(3, 100);

        // Asynchronous reset in the middle of a sweep, then a clean sweep
        small_diff_luts();
        start = 1'b1;
        step(2);
        start = 1'b0;
        guard = 0;
        while (sx(x_out) != 10 && guard < 300) begin
            step(2);
            guard++;
        end
        chk("s4_reach_x10", sx(x_out), 10);
        #2 reset = 1'b1;
        model_edge(1'b0, 1'b0, 1'b1);
        #1;
        chk("s4_rst_x", sx(x_out), 0);
        chk("s4_rst_busy", int'(busy), 0);
        chk("s4_rst_done", int'(done), 0);
        chk("s4_rst_cnt", int'(mismatch_cnt), 0);
        chk("s4_rst_max", int'(max_err), 0);
        chk("s4_rst_ovf", int'(overflow), 0);
        chk("s4_rst_valid", int'(eif.err_valid), 0);
        step(2);
        step(2);
        #2 reset = 1'b0;
        run_sweep(2, -1);

        // Fully random responses, mostly stalled consumer
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'($urandom);
            lut_b[i] = 8'($urandom);
        end
        run_sweep(3, -1);
        repeat (40) step(2);

`ifdef ERR_HIST_EN
        for (int i = 0; i < 256; i++) begin
            lut_a[i] = 8'($urandom_range(0, 200) - 100);
            lut_b[i] = 8'(sx(lut_a[i]) + (i & 3));
        end
        run_sweep(1, -1);
        chk("s6_hist0", int'(hist0), 64);
        chk("s6_hist1", int'(hist1), 64);
        chk("s6_hist2", int'(hist2), 128);
        chk("s6_hist3", int'(hist3), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
